// File: rtl/writeback_if.sv
// Bundle between execute/decode and the write-back buffer: result handshake,
// register file write port, bypass lookups and occupancy.
interface writeback_if #(
  parameter int N_REG_ADDR = 5,
  parameter int N_DATA     = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N_REG_ADDR-1:0] in_rd;
  logic [N_DATA-1:0]     in_data;
  logic                  rd_req;
  logic                  rd_stall;
  logic [N_REG_ADDR-1:0] rf_addr_3;
  logic                  rf_we_3;
  logic [N_DATA-1:0]     rf_wdata_3;
  logic [N_REG_ADDR-1:0] byp_addr_1;
  logic [N_REG_ADDR-1:0] byp_addr_2;
  logic                  byp_hit_1;
  logic                  byp_hit_2;
  logic [N_DATA-1:0]     byp_data_1;
  logic [N_DATA-1:0]     byp_data_2;
  logic [1:0]            count;

  modport master (
    output in_valid, in_rd, in_data, rd_req, byp_addr_1, byp_addr_2,
    input  in_ready, rd_stall, rf_addr_3, rf_we_3, rf_wdata_3,
           byp_hit_1, byp_hit_2, byp_data_1, byp_data_2, count
  );

  modport slave (
    input  in_valid, in_rd, in_data, rd_req, byp_addr_1, byp_addr_2,
    output in_ready, rd_stall, rf_addr_3, rf_we_3, rf_wdata_3,
           byp_hit_1, byp_hit_2, byp_data_1, byp_data_2, count
  );
endinterface

// File: rtl/writeback_stage.sv
// Two-entry write-back FIFO feeding the register file write port; writes yield
// to decode reads unless full, and buffered results are exposed for bypass.
module writeback_stage #(
  parameter int N_REG_ADDR = 5,
  parameter int N_DATA     = 32,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  writeback_if.slave  wb
);
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [N_REG_ADDR-1:0] rd_mem   [2];
  logic [N_DATA-1:0]     data_mem [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            count_q;

  logic nonempty;
  logic full;
  logic push;
  logic pop;

  assign nonempty = (count_q != 2'd0);
  assign full     = (count_q == DEPTH_C);

  assign wb.in_ready = rst_n && (count_q < DEPTH_C);
  assign push        = wb.in_valid && wb.in_ready && (wb.in_rd != '0);
  assign pop         = nonempty && (!wb.rd_req || full);

  assign wb.rf_we_3    = pop;
  assign wb.rf_addr_3  = pop ? rd_mem[head]   : '0;
  assign wb.rf_wdata_3 = pop ? data_mem[head] : '0;
  assign wb.rd_stall   = wb.rd_req && pop;
  assign wb.count      = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= 1'b0;
      tail    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= wb.in_rd;
      data_mem[tail] <= wb.in_data;
    end
  end

  // Youngest valid entry sits just behind tail; the older one is head when full.
  function automatic logic [N_DATA:0] lookup(
    input logic [N_REG_ADDR-1:0] addr,
    input logic                  y_ok,
    input logic [N_REG_ADDR-1:0] y_rd,
    input logic [N_DATA-1:0]     y_data,
    input logic                  o_ok,
    input logic [N_REG_ADDR-1:0] o_rd,
    input logic [N_DATA-1:0]     o_data
  );
    logic [N_DATA:0] r;
    r = '0;
    if (addr != '0) begin
      if (y_ok && (y_rd == addr))      r = {1'b1, y_data};
      else if (o_ok && (o_rd == addr)) r = {1'b1, o_data};
    end
    return r;
  endfunction

  logic [N_DATA:0] hit_1;
  logic [N_DATA:0] hit_2;

  always_comb begin
    hit_1 = lookup(wb.byp_addr_1, nonempty, rd_mem[~tail], data_mem[~tail],
                   full, rd_mem[head], data_mem[head]);
    hit_2 = lookup(wb.byp_addr_2, nonempty, rd_mem[~tail], data_mem[~tail],
                   full, rd_mem[head], data_mem[head]);
  end

  assign wb.byp_hit_1  = hit_1[N_DATA];
  assign wb.byp_data_1 = hit_1[N_DATA-1:0];
  assign wb.byp_hit_2  = hit_2[N_DATA];
  assign wb.byp_data_2 = hit_2[N_DATA-1:0];
endmodule
